// File: rtl/inter_core_mbox_fifo.sv
// rtl/inter_core_mbox_fifo.sv - multi-channel inter-core mailbox FIFO with push and pop slave ports
module inter_core_mbox_fifo #(
   parameter int NumChannels = 4,
   parameter int Depth       = 8,
   parameter int DataWidth   = 32,
   parameter int AddrWidth   = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_req_i,
   input  logic [AddrWidth-1:0]   push_add_i,
   input  logic                   push_wen_i,
   input  logic [DataWidth-1:0]   push_wdata_i,
   output logic                   push_gnt_o,
   output logic                   push_r_valid_o,
   output logic [DataWidth-1:0]   push_r_rdata_o,
   output logic                   push_r_opc_o,
   input  logic                   pop_req_i,
   input  logic [AddrWidth-1:0]   pop_add_i,
   input  logic                   pop_wen_i,
   input  logic [DataWidth-1:0]   pop_wdata_i,
   output logic                   pop_gnt_o,
   output logic                   pop_r_valid_o,
   output logic [DataWidth-1:0]   pop_r_rdata_o,
   output logic                   pop_r_opc_o,
   output logic [NumChannels-1:0] nonempty_o,
   output logic [NumChannels-1:0] full_o
);
   localparam int ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
   localparam int UW  = $clog2(Depth + 1);
   localparam int PW  = $clog2(Depth);
   localparam logic [UW-1:0] UsageFull = UW'(Depth);
   localparam logic [PW-1:0] PtrLast   = PW'(Depth - 1);

   logic [DataWidth-1:0] mem    [NumChannels][Depth];
   logic [PW-1:0]        rd_ptr [NumChannels];
   logic [PW-1:0]        wr_ptr [NumChannels];
   logic [UW-1:0]        usage  [NumChannels];

   logic [ChW-1:0]       push_ch, pop_ch, push_idx, pop_idx;
   logic [1:0]           push_off, pop_off;
   logic                 push_ch_ok, pop_ch_ok;
   logic [UW-1:0]        push_usage, pop_usage;
   logic                 push_full, pop_empty;
   logic                 push_gnt, pop_gnt, push_en, pop_en, flush;
   logic [DataWidth-1:0] push_rdata, pop_rdata;
   logic                 push_opc, pop_opc;
   logic [NumChannels-1:0] ch_push, ch_pop, ch_flush;
   logic                 unused_bits;

   assign unused_bits = ^{push_add_i, pop_add_i, pop_wdata_i};

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PtrLast) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [DataWidth-1:0] usage_word(input logic [UW-1:0] u);
      return {{(DataWidth-UW){1'b0}}, u};
   endfunction

   function automatic logic [DataWidth-1:0] status_word(input logic [UW-1:0] u);
      return {{(DataWidth-2){1'b0}}, u == UsageFull, u == '0};
   endfunction

   assign push_ch    = push_add_i[4 +: ChW];
   assign pop_ch     = pop_add_i[4 +: ChW];
   assign push_off   = push_add_i[3:2];
   assign pop_off    = pop_add_i[3:2];
   assign push_ch_ok = int'(push_ch) < NumChannels;
   assign pop_ch_ok  = int'(pop_ch) < NumChannels;
   // Out-of-range channels still need a legal array index; their effects are masked below.
   assign push_idx   = push_ch_ok ? push_ch : '0;
   assign pop_idx    = pop_ch_ok ? pop_ch : '0;

   always_comb begin
      push_usage = usage[push_idx];
      pop_usage  = usage[pop_idx];
      push_full  = push_usage == UsageFull;
      pop_empty  = pop_usage == '0;

      pop_gnt   = 1'b1;
      pop_en    = 1'b0;
      flush     = 1'b0;
      pop_rdata = '0;
      pop_opc   = 1'b0;
      if (!pop_ch_ok) begin
         pop_opc = 1'b1;
      end else begin
         case (pop_off)
            2'd0: if (pop_wen_i) begin
               pop_gnt = !pop_empty;
               pop_en  = !pop_empty;
            end
            2'd1: if (pop_wen_i) begin
               pop_en  = !pop_empty;
               pop_opc = pop_empty;
            end
            2'd2: if (pop_wen_i) pop_rdata = usage_word(pop_usage);
            default: begin
               if (pop_wen_i) pop_rdata = status_word(pop_usage);
               else           flush     = 1'b1;
            end
         endcase
      end
      if (pop_en) pop_rdata = mem[pop_idx][rd_ptr[pop_idx]];
      pop_gnt = pop_gnt & pop_req_i;
      pop_en  = pop_en & pop_req_i;
      flush   = flush & pop_req_i;

      push_gnt   = 1'b1;
      push_en    = 1'b0;
      push_rdata = '0;
      push_opc   = 1'b0;
      if (!push_ch_ok) begin
         push_opc = 1'b1;
      end else if (flush && (pop_ch == push_ch)) begin
         push_gnt = 1'b0;
      end else begin
         case (push_off)
            2'd0: if (!push_wen_i) begin
               push_gnt = !push_full;
               push_en  = !push_full;
            end
            2'd1: if (!push_wen_i) begin
               push_en  = !push_full;
               push_opc = push_full;
            end
            2'd2: if (push_wen_i) push_rdata = usage_word(push_usage);
            default: if (push_wen_i) push_rdata = status_word(push_usage);
         endcase
      end
      push_gnt = push_gnt & push_req_i;
      push_en  = push_en & push_req_i;
   end

   assign push_gnt_o = push_gnt;
   assign pop_gnt_o  = pop_gnt;

   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      assign ch_push[c]    = push_en && (push_idx == ChW'(c));
      assign ch_pop[c]     = pop_en && (pop_idx == ChW'(c));
      assign ch_flush[c]   = flush && (pop_idx == ChW'(c));
      assign nonempty_o[c] = usage[c] != '0;
      assign full_o[c]     = usage[c] == UsageFull;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NumChannels; c++) begin
            rd_ptr[c] <= '0;
            wr_ptr[c] <= '0;
            usage[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NumChannels; c++) begin
            if (ch_flush[c]) begin
               rd_ptr[c] <= '0;
               wr_ptr[c] <= '0;
               usage[c]  <= '0;
            end else begin
               if (ch_push[c]) wr_ptr[c] <= next_ptr(wr_ptr[c]);
               if (ch_pop[c])  rd_ptr[c] <= next_ptr(rd_ptr[c]);
               if (ch_push[c] && !ch_pop[c])      usage[c] <= usage[c] + UW'(1);
               else if (ch_pop[c] && !ch_push[c]) usage[c] <= usage[c] - UW'(1);
            end
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (push_en) mem[push_idx][wr_ptr[push_idx]] <= push_wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         push_r_valid_o <= 1'b0;
         push_r_rdata_o <= '0;
         push_r_opc_o   <= 1'b0;
         pop_r_valid_o  <= 1'b0;
         pop_r_rdata_o  <= '0;
         pop_r_opc_o    <= 1'b0;
      end else begin
         push_r_valid_o <= push_gnt;
         push_r_rdata_o <= push_gnt ? push_rdata : '0;
         push_r_opc_o   <= push_gnt & push_opc;
         pop_r_valid_o  <= pop_gnt;
         pop_r_rdata_o  <= pop_gnt ? pop_rdata : '0;
         pop_r_opc_o    <= pop_gnt & pop_opc;
      end
   end
endmodule

// File: tb/tb_inter_core_mbox_fifo.sv
// tb/tb_inter_core_mbox_fifo.sv - self-checking bench for inter_core_mbox_fifo
module tb_inter_core_mbox_fifo;
   localparam int DEPTH = 8;
   localparam int NCH   = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        push_req, push_wen, push_gnt, push_r_valid, push_r_opc;
   logic [31:0] push_add, push_wdata, push_r_rdata;
   logic        pop_req, pop_wen, pop_gnt, pop_r_valid, pop_r_opc;
   logic [31:0] pop_add, pop_wdata, pop_r_rdata;
   logic [3:0]  nonempty, full;

   int checks = 0;
   int errors = 0;
   logic [31:0] mq [NCH][$];

   typedef struct {
      logic pr; logic [31:0] pa; logic pw; logic [31:0] pd;
      logic orq; logic [31:0] oa; logic ow;
      logic epg; logic [31:0] eprd; logic epopc;
      logic eog; logic [31:0] eord; logic eoopc;
      logic [3:0] ene; logic [3:0] efu;
   } vec_t;
   vec_t tbl[$];

   inter_core_mbox_fifo dut (
      .clk_i(clk), .rst_ni(rst_n),
      .push_req_i(push_req), .push_add_i(push_add), .push_wen_i(push_wen), .push_wdata_i(push_wdata),
      .push_gnt_o(push_gnt), .push_r_valid_o(push_r_valid), .push_r_rdata_o(push_r_rdata),
      .push_r_opc_o(push_r_opc),
      .pop_req_i(pop_req), .pop_add_i(pop_add), .pop_wen_i(pop_wen), .pop_wdata_i(pop_wdata),
      .pop_gnt_o(pop_gnt), .pop_r_valid_o(pop_r_valid), .pop_r_rdata_o(pop_r_rdata),
      .pop_r_opc_o(pop_r_opc),
      .nonempty_o(nonempty), .full_o(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic pr, input logic [31:0] pa, input logic pw, input logic [31:0] pd,
                               input logic orq, input logic [31:0] oa, input logic ow,
                               input logic epg, input logic [31:0] eprd, input logic epopc,
                               input logic eog, input logic [31:0] eord, input logic eoopc,
                               input logic [3:0] ene, input logic [3:0] efu);
      vec_t v;
      v.pr = pr; v.pa = pa; v.pw = pw; v.pd = pd; v.orq = orq; v.oa = oa; v.ow = ow;
      v.epg = epg; v.eprd = eprd; v.epopc = epopc; v.eog = eog; v.eord = eord; v.eoopc = eoopc;
      v.ene = ene; v.efu = efu;
      return v;
   endfunction

   function automatic logic [31:0] stat(input int n);
      return {30'd0, n == DEPTH, n == 0};
   endfunction

   // Reference: each channel is a plain queue, usage is its size.
   task automatic model_eval(input logic pr, input logic [31:0] pa, input logic pw, input logic [31:0] pd,
                             input logic orq, input logic [31:0] oa, input logic ow,
                             output logic e_pg, output logic [31:0] e_prd, output logic e_popc,
                             output logic e_og, output logic [31:0] e_ord, output logic e_oopc);
      int pc, po, oc, oo, psz, osz;
      logic do_push, do_pop, do_flush;
      pc = int'(pa[5:4]); po = int'(pa[3:2]); oc = int'(oa[5:4]); oo = int'(oa[3:2]);
      psz = mq[pc].size(); osz = mq[oc].size();
      do_push = 0; do_pop = 0; do_flush = 0;
      e_og = 0; e_ord = 0; e_oopc = 0;
      if (orq) begin
         e_og = 1;
         if (oo == 0 && ow) begin e_og = osz != 0; do_pop = e_og; end
         else if (oo == 1 && ow) begin if (osz == 0) e_oopc = 1; else do_pop = 1; end
         else if (oo == 2 && ow) e_ord = osz;
         else if (oo == 3 && ow) e_ord = stat(osz);
         else if (oo == 3) do_flush = 1;
         if (do_pop) e_ord = mq[oc][0];
      end
      e_pg = 0; e_prd = 0; e_popc = 0;
      if (pr) begin
         e_pg = 1;
         if (do_flush && oc == pc) e_pg = 0;
         else if (po == 0 && !pw) begin e_pg = psz < DEPTH; do_push = e_pg; end
         else if (po == 1 && !pw) begin if (psz == DEPTH) e_popc = 1; else do_push = 1; end
         else if (po == 2 && pw) e_prd = psz;
         else if (po == 3 && pw) e_prd = stat(psz);
      end
      if (do_pop) void'(mq[oc].pop_front());
      if (do_push) mq[pc].push_back(pd);
      if (do_flush) mq[oc].delete();
   endtask

   task automatic tick(output logic pg, output logic og);
      @(negedge clk);
      pg = push_gnt;
      og = pop_gnt;
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycle(input logic pr, input logic [31:0] pa, input logic pw, input logic [31:0] pd,
                            input logic orq, input logic [31:0] oa, input logic ow,
                            output logic pg, output logic og);
      logic e_pg, e_popc, e_og, e_oopc;
      logic [31:0] e_prd, e_ord;
      logic [3:0] e_ne, e_fu;
      push_req = pr; push_add = pa; push_wen = pw; push_wdata = pd;
      pop_req = orq; pop_add = oa; pop_wen = ow; pop_wdata = $urandom;
      model_eval(pr, pa, pw, pd, orq, oa, ow, e_pg, e_prd, e_popc, e_og, e_ord, e_oopc);
      tick(pg, og);
      if (pr) chk("mdl_push_gnt", pg, e_pg);
      if (orq) chk("mdl_pop_gnt", og, e_og);
      chk("mdl_push_valid", push_r_valid, e_pg);
      chk("mdl_pop_valid", pop_r_valid, e_og);
      if (e_pg) begin
         chk("mdl_push_rdata", push_r_rdata, e_prd);
         chk("mdl_push_opc", push_r_opc, e_popc);
      end
      if (e_og) begin
         chk("mdl_pop_rdata", pop_r_rdata, e_ord);
         chk("mdl_pop_opc", pop_r_opc, e_oopc);
      end
      for (int c = 0; c < NCH; c++) begin
         e_ne[c] = mq[c].size() != 0;
         e_fu[c] = mq[c].size() == DEPTH;
      end
      chk("mdl_nonempty", nonempty, e_ne);
      chk("mdl_full", full, e_fu);
   endtask

   task automatic idle();
      push_req = 0; push_add = 0; push_wen = 0; push_wdata = 0;
      pop_req = 0; pop_add = 0; pop_wen = 0; pop_wdata = 0;
   endtask

   initial begin
      logic pg, og;
      int n;
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_push_valid", push_r_valid, 0);
      chk("rst_push_rdata", push_r_rdata, 0);
      chk("rst_push_opc", push_r_opc, 0);
      chk("rst_pop_valid", pop_r_valid, 0);
      chk("rst_pop_rdata", pop_r_rdata, 0);
      chk("rst_pop_opc", pop_r_opc, 0);
      chk("rst_nonempty", nonempty, 0);
      chk("rst_full", full, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1, 32'h10, 0, 32'hA0 + i, 0, 0, 0, 1, 0, 0, 0, 0, 0,
                          4'b0010, (i == 7) ? 4'b0010 : 4'b0000));
      tbl.push_back(mk(1, 32'h1C, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 4'b0010, 4'b0010));
      tbl.push_back(mk(1, 32'h18, 1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 4'b0010, 4'b0010));
      tbl.push_back(mk(1, 32'h14, 0, 32'hFF, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4'b0010, 4'b0010));
      tbl.push_back(mk(1, 32'h10, 0, 32'hEE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 4'b0010));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1, 0, 0, 0, 1, 32'hA0 + i, 0,
                          (i == 7) ? 4'b0000 : 4'b0010, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h24, 1, 0, 0, 0, 1, 0, 1, 4'b0000, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h1C, 1, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b0000));
      tbl.push_back(mk(1, 32'h20, 0, 32'h5A, 1, 32'h2C, 1, 1, 0, 0, 1, 1, 0, 4'b0100, 4'b0000));
      tbl.push_back(mk(1, 32'h28, 1, 0, 1, 32'h24, 1, 1, 1, 0, 1, 32'h5A, 0, 4'b0000, 4'b0000));

      foreach (tbl[i]) begin
         run_cycle(tbl[i].pr, tbl[i].pa, tbl[i].pw, tbl[i].pd, tbl[i].orq, tbl[i].oa, tbl[i].ow, pg, og);
         if (tbl[i].pr) chk($sformatf("tbl%0d_push_gnt", i), pg, tbl[i].epg);
         if (tbl[i].orq) chk($sformatf("tbl%0d_pop_gnt", i), og, tbl[i].eog);
         chk($sformatf("tbl%0d_push_valid", i), push_r_valid, tbl[i].pr & tbl[i].epg);
         chk($sformatf("tbl%0d_pop_valid", i), pop_r_valid, tbl[i].orq & tbl[i].eog);
         if (tbl[i].pr && tbl[i].epg) begin
            chk($sformatf("tbl%0d_push_rdata", i), push_r_rdata, tbl[i].eprd);
            chk($sformatf("tbl%0d_push_opc", i), push_r_opc, tbl[i].epopc);
         end
         if (tbl[i].orq && tbl[i].eog) begin
            chk($sformatf("tbl%0d_pop_rdata", i), pop_r_rdata, tbl[i].eord);
            chk($sformatf("tbl%0d_pop_opc", i), pop_r_opc, tbl[i].eoopc);
         end
         chk($sformatf("tbl%0d_nonempty", i), nonempty, tbl[i].ene);
         chk($sformatf("tbl%0d_full", i), full, tbl[i].efu);
      end

      // Blocking push held against a full channel until one pop frees a slot.
      for (int i = 0; i < DEPTH; i++) run_cycle(1, 32'h00, 0, 32'hC0 + i, 0, 0, 0, pg, og);
      for (int i = 0; i < 3; i++) begin
         run_cycle(1, 32'h00, 0, 32'h55, 0, 0, 0, pg, og);
         chk("blk_push_full_gnt", pg, 0);
      end
      run_cycle(1, 32'h00, 0, 32'h55, 1, 32'h00, 1, pg, og);
      chk("blk_push_with_pop_gnt", pg, 0);
      chk("blk_pop_gnt", og, 1);
      chk("blk_pop_data", pop_r_rdata, 32'hC0);
      run_cycle(1, 32'h00, 0, 32'h55, 0, 0, 0, pg, og);
      chk("blk_push_after_pop_gnt", pg, 1);
      run_cycle(1, 32'h08, 1, 0, 0, 0, 0, pg, og);
      chk("blk_usage8", push_r_rdata, 8);
      run_cycle(1, 32'h04, 0, 32'h66, 0, 0, 0, pg, og);
      chk("nb_push_full_opc", push_r_opc, 1);
      run_cycle(1, 32'h08, 1, 0, 0, 0, 0, pg, og);
      chk("nb_push_full_usage", push_r_rdata, 8);

      // Usage 1 with two back-to-back blocking pops.
      run_cycle(1, 32'h30, 0, 32'h33, 0, 0, 0, pg, og);
      run_cycle(0, 0, 0, 0, 1, 32'h30, 1, pg, og);
      chk("u1_pop1_gnt", og, 1);
      chk("u1_pop1_data", pop_r_rdata, 32'h33);
      chk("u1_nonempty3", nonempty[3], 0);
      run_cycle(0, 0, 0, 0, 1, 32'h30, 1, pg, og);
      chk("u1_pop2_gnt", og, 0);

      // Concurrent push/pop at usage 4 across pointer wraps.
      run_cycle(0, 0, 0, 0, 1, 32'h0C, 0, pg, og);
      for (int i = 0; i < 4; i++) run_cycle(1, 32'h00, 0, 32'h200 + i, 0, 0, 0, pg, og);
      for (int i = 0; i < 20; i++) begin
         run_cycle(1, 32'h00, 0, 32'h300 + i, 1, 32'h00, 1, pg, og);
         chk("pp_push_gnt", pg, 1);
         chk("pp_pop_gnt", og, 1);
         chk("pp_pop_data", pop_r_rdata, (i < 4) ? 32'h200 + i : 32'h300 + i - 4);
      end
      run_cycle(1, 32'h08, 1, 0, 0, 0, 0, pg, og);
      chk("pp_usage4", push_r_rdata, 4);

      // Flush at usage 5 racing a push to the same channel.
      for (int i = 0; i < 5; i++) run_cycle(1, 32'h10, 0, 32'h400 + i, 0, 0, 0, pg, og);
      run_cycle(1, 32'h10, 0, 32'h4FF, 1, 32'h1C, 0, pg, og);
      chk("fl_push_gnt", pg, 0);
      chk("fl_pop_gnt", og, 1);
      run_cycle(1, 32'h18, 1, 0, 0, 0, 0, pg, og);
      chk("fl_usage0", push_r_rdata, 0);
      chk("fl_nonempty1", nonempty[1], 0);

      // Reset in the middle of a granted request aborts its response.
      run_cycle(1, 32'h00, 0, 32'h77, 1, 32'h30, 1, pg, og);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("mid_rst_push_valid", push_r_valid, 0);
      chk("mid_rst_nonempty", nonempty, 0);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_pop_rdata", pop_r_rdata, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_no_resp", push_r_valid, 0);
      idle();
      for (int c = 0; c < NCH; c++) mq[c].delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_cycle(1, 32'h08, 1, 0, 0, 0, 0, pg, og);
      chk("post_rst_usage", push_r_rdata, 0);

      // Randomized traffic against the queue model.
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         logic        pr, pw, orq, ow;
         logic [31:0] pa, oa;
         int          po;
         po  = $urandom_range(0, 5);
         po  = (po < 3) ? 0 : po - 2;
         pr  = $urandom_range(0, 9) < 7;
         pw  = $urandom_range(0, 3) == 0;
         pa  = ($urandom & 32'hFFFF_FFC0) | ($urandom_range(0, 3) << 4) | (po << 2);
         orq = $urandom_range(0, 1);
         ow  = $urandom_range(0, 5) != 0;
         oa  = ($urandom & 32'hFFFF_FFC0) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
         run_cycle(pr, pa, pw, $urandom, orq, oa, ow, pg, og);
         n++;
      end
      chk("rand_cycles", n, 2000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
